// File: rtl/adder_serial.sv
// Digit-serial adder: adds a + b + c_in DIGIT bits per clock over WIDTH/DIGIT cycles,
// with start/busy/done handshake, carry-out and signed overflow held until next completion.
module adder_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             c_out,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] psum;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT:0]   dig;
   logic [DIGIT-1:0] digit_sum;
   logic             digit_carry;
   logic             msb_carry;
   logic [WIDTH-1:0] psum_next;
   logic             last;

   always_comb begin
      dig         = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
      digit_sum   = dig[DIGIT-1:0];
      digit_carry = dig[DIGIT];
      // Carry into the top bit of this digit, recovered from the sum bit and its operands.
      msb_carry   = digit_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
      psum_next   = WIDTH'({digit_sum, psum} >> DIGIT);
      last        = (cnt == CW'(N - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         psum     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         c_out    <= 1'b0;
         sum      <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= c_in;
                  psum  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               psum  <= psum_next;
               carry <= digit_carry;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  sum      <= psum_next;
                  c_out    <= digit_carry;
                  overflow <= msb_carry ^ digit_carry;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
